// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the byte-serial data-memory word arbiter.
// Holds the FSM state enum, owner type, word geometry and byte-lane helpers.
package dmem_arb_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Counter value of the final byte cycle of a word access
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    // 0 = processor load/store, 1 = loader/debug
    typedef logic owner_t;

    // Big-endian lane pick: lane 0 is bits [31:24]
    function automatic logic [7:0] lane_sel(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Big-endian lane replace: returns w with lane idx set to b
    function automatic logic [31:0] lane_put(
        input logic [31:0] w,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        unique case (idx)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            default: r[7:0] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two word requesters.
// Ports: req[1:0] in, last_owner in; any/win out. Macro DMEM_ARB_RR_EN picks round-robin ties.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       any,
    output owner_t     win
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        any = |req;
        win = req[1];
        // On a tie, hand the memory to whoever did not have it last
        if (&req) begin
            win = ~last_owner;
        end
    end
`else
    // Fixed priority: last_owner is tracked by the top but not consulted
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        any = |req;
        win = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/dmem_word_arbiter.sv
// Shares one byte-wide datmem between two 32-bit requesters, 4 big-endian byte cycles per word.
// Ports: clk, rst_n (sync, active-low); r0_*/r1_* req/we/addr/wdata in, gnt/done/rdata out;
//        mem_addr/mem_we/mem_wdata out, mem_rdata in (async read); busy out.
// Build macro: DMEM_ARB_RR_EN enables round-robin tie-breaking (default fixed priority, port 0).
module dmem_word_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          cnt_q;
    owner_t              owner_q;
    owner_t              last_owner_q;
    owner_t              win;
    logic                any_req;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   r0_rdata_q;
    logic [DATA_W-1:0]   r1_rdata_q;
    logic [1:0]          gnt_q;

    dmem_arb_pick u_pick (
        .req        ({r1_req, r0_req}),
        .last_owner (last_owner_q),
        .any        (any_req),
        .win        (win)
    );

    always_comb begin
        state_d   = state_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        r0_done   = 1'b0;
        r1_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // Base plus lane offset wraps modulo the memory depth
                mem_addr  = addr_q + ADDR_W'(cnt_q);
                // Gated by rst_n so a reset cycle never writes a byte
                mem_we    = we_q & rst_n;
                mem_wdata = lane_sel(wdata_q, cnt_q);
                if (cnt_q == LAST_BYTE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                r0_done = ~owner_q;
                r1_done = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            gnt_q        <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (any_req) begin
                        owner_q      <= win;
                        last_owner_q <= win;
                        gnt_q[win]   <= 1'b1;
                        we_q         <= win ? r1_we    : r0_we;
                        addr_q       <= win ? r1_addr  : r0_addr;
                        wdata_q      <= win ? r1_wdata : r0_wdata;
                    end
                end
                XFER: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (!we_q) begin
                        rdata_q <= lane_put(rdata_q, cnt_q, mem_rdata);
                        // Last byte lands straight in the owner's result
                        if (cnt_q == LAST_BYTE) begin
                            if (owner_q) begin
                                r1_rdata_q <= lane_put(rdata_q, cnt_q, mem_rdata);
                            end else begin
                                r0_rdata_q <= lane_put(rdata_q, cnt_q, mem_rdata);
                            end
                        end
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign r0_gnt   = gnt_q[0];
    assign r1_gnt   = gnt_q[1];
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_word_arbiter.sv
// Scoreboard bench for dmem_word_arbiter with a byte memory model.
// Expected grants/dones are queued by the stimulus and popped by a monitor.
module tb_dmem_word_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [4:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_done, r1_gnt, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    bit   gq[$];
    exp_t dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [32] = '{default: 8'h5A};

    dmem_word_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_done   (r0_done),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_done   (r1_done),
        .r1_rdata  (r1_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    // Monitor: compare every gnt/done pulse against the queues
    bit   mon_p;
    exp_t mon_e;
    always @(negedge clk) begin
        if (r0_gnt || r1_gnt) begin
            checks++;
            if (r0_gnt && r1_gnt) begin
                errors++;
                $display("FAIL gnt_both: r0_gnt=1 r1_gnt=1 required one");
            end else if (gq.size() == 0) begin
                errors++;
                $display("FAIL gnt_extra: port %0d granted, none expected",
                         r1_gnt);
            end else begin
                mon_p = gq.pop_front();
                if (mon_p != r1_gnt) begin
                    errors++;
                    $display("FAIL gnt_port: got port %0d required %0d",
                             r1_gnt, mon_p);
                end
            end
        end
        if (r0_done || r1_done) begin
            checks++;
            if (r0_done && r1_done) begin
                errors++;
                $display("FAIL done_both: r0_done=1 r1_done=1 required one");
            end else if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_extra: port %0d done, none expected",
                         r1_done);
            end else begin
                mon_e = dq.pop_front();
                if (mon_e.port != r1_done) begin
                    errors++;
                    $display("FAIL done_port: got port %0d required %0d",
                             r1_done, mon_e.port);
                end else if (mon_e.rd &&
                             (r1_done ? r1_rdata : r0_rdata) !== mon_e.data) begin
                    errors++;
                    $display("FAIL done_rdata p%0d: got %h required %h",
                             mon_e.port, r1_done ? r1_rdata : r0_rdata,
                             mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic expect_txn(input bit p, input bit rd,
                              input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.rd   = rd;
        e.data = d;
        gq.push_back(p);
        dq.push_back(e);
    endtask

    task automatic drive(input bit p, input bit we, input logic [4:0] a,
                         input logic [31:0] wd);
        if (p) begin
            r1_we = we; r1_addr = a; r1_wdata = wd; r1_req = 1'b1;
        end else begin
            r0_we = we; r0_addr = a; r0_wdata = wd; r0_req = 1'b1;
        end
    endtask

    task automatic wait_pulse(input bit p, input bit d, output int c);
        logic s;
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s = d ? (p ? r1_done : r0_done) : (p ? r1_gnt : r0_gnt);
            if (s) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout p%0d %s: got none required pulse",
                     p, d ? "done" : "gnt");
        end
    endtask

    task automatic run_one(input bit p, input bit we, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] exp,
                           output int gc, output int dc);
        expect_txn(p, !we, exp);
        drive(p, we, a, wd);
        wait_pulse(p, 1'b0, gc);
        if (p) r1_req = 1'b0; else r0_req = 1'b0;
        wait_pulse(p, 1'b1, dc);
    endtask

    int  c0, g, d, g1, d0;
    int  gcy[4];
    bit  seq[4];

    initial begin
        rst_n = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        repeat (3) @(negedge clk);

        chk("rst_r0_gnt",   32'(r0_gnt),   0);
        chk("rst_r1_gnt",   32'(r1_gnt),   0);
        chk("rst_r0_done",  32'(r0_done),  0);
        chk("rst_r1_done",  32'(r1_done),  0);
        chk("rst_r0_rdata", r0_rdata,      0);
        chk("rst_r1_rdata", r1_rdata,      0);
        chk("rst_mem_we",   32'(mem_we),   0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wd",   32'(mem_wdata), 0);
        chk("rst_busy",     32'(busy),     0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: port 0 write to 4
        c0 = cyc;
        run_one(0, 1, 5'd4, 32'hDEADBEEF, 0, g, d);
        chk("t1_gnt_lat", 32'(g - c0), 1);
        chk("t1_done_lat", 32'(d - g), 4);
        chk("t1_busy_done", 32'(busy), 1);
        @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);

        // 2: port 1 read back
        run_one(1, 0, 5'd4, 0, 32'hDEADBEEF, g, d);
        repeat (3) @(negedge clk);
        chk("t2_hold", r1_rdata, 32'hDEADBEEF);

        // 3: wrapping write at 30, then wrapping read on port 1
        run_one(0, 1, 5'd30, 32'h11223344, 0, g, d);
        chk("t3_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
        chk("t3_mem2", 32'(mem[2]), 32'h5A);
        run_one(1, 0, 5'd30, 0, 32'h11223344, g, d);

        // 4: both requesting for four transactions
`ifdef DMEM_ARB_RR_EN
        seq = '{0, 1, 0, 1};
`else
        seq = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            expect_txn(seq[k], 1'b1,
                       seq[k] ? 32'h11223344 : 32'hDEADBEEF);
        end
        drive(0, 0, 5'd4, 0);
        drive(1, 0, 5'd30, 0);
        for (int k = 0; k < 4; k++) begin
            gcy[k] = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (r0_gnt || r1_gnt) begin
                    gcy[k] = cyc;
                    break;
                end
            end
            if (gcy[k] < 0) begin
                checks++;
                errors++;
                $display("FAIL t4_timeout: got no grant %0d required one", k);
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        for (int i = 0; i < 40 && dq.size() != 0; i++) @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            chk("t4_period", 32'(gcy[k] - gcy[k-1]), 6);
        end

        // 5: reset during the third byte of a write to 8
        gq.push_back(1'b0);
        drive(0, 1, 5'd8, 32'hAABBCCDD);
        wait_pulse(0, 1'b0, g);
        r0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_we_gated", 32'(mem_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_busy",     32'(busy),      0);
        chk("t5_mem_we",   32'(mem_we),    0);
        chk("t5_mem_addr", 32'(mem_addr),  0);
        chk("t5_mem_wd",   32'(mem_wdata), 0);
        chk("t5_r0_rdata", r0_rdata,       0);
        chk("t5_r1_rdata", r1_rdata,       0);
        chk("t5_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB5A5A);
        run_one(1, 0, 5'd8, 0, 32'hAABB5A5A, g, d);

        // 6: port 1 asks while port 0 is transferring
        expect_txn(0, 1'b0, 0);
        expect_txn(1, 1'b1, 32'h01020304);
        drive(0, 1, 5'd12, 32'h01020304);
        wait_pulse(0, 1'b0, g);
        r0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(1, 0, 5'd12, 0);
        wait_pulse(0, 1'b1, d0);
        wait_pulse(1, 1'b0, g1);
        r1_req = 1'b0;
        chk("t6_gnt_gap", 32'(g1 - d0), 2);
        wait_pulse(1, 1'b1, d);

        repeat (3) @(negedge clk);
        chk("queues_empty", 32'(gq.size() + dq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
